check_slider: RTL and testbench
===============================

CHECK_SLIDER -- requirements
Module: check_slider

Interface
REQ-001 SHALL provide parameter BOARD_N, default 8, board edge length in squares (2..16).
REQ-002 SHALL provide parameter COORD_W, default $clog2(BOARD_N), coordinate width.
REQ-003 SHALL provide parameter PIECE_W, default 4, piece code width.
REQ-004 SHALL provide parameter ALLOW_DIAG, default 1, diagonal moves permitted (bishop/queen).
REQ-005 SHALL provide parameter ALLOW_ORTHO, default 1, rank/file moves permitted (rook/queen).
REQ-006 SHALL have port CLOCK_50  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port start  input  1  request pulse; accepted only in IDLE.
REQ-009 SHALL have ports old_x, old_y  input  COORD_W each  source square.
REQ-010 SHALL have ports new_x, new_y  input  COORD_W each  destination square.
REQ-011 SHALL have port board_in  input  [BOARD_N][BOARD_N] x PIECE_W  board array, indexed [x][y].
REQ-012 SHALL have port busy  output  1  high from the cycle after acceptance until DONE is exited.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port move_valid  output  1  verdict; held from done until the next accepted start.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> WALK -> DONE -> IDLE.
REQ-016 SHALL latch old/new coordinates on an accepted start (cycle T); SETUP occupies T+1.
REQ-017 SHALL, in SETUP, compute dx = new_x-old_x and dy = new_y-old_y signed at COORD_W+1 bits; step = sign(dx), sign(dy).
REQ-018 SHALL classify geometry: diagonal if |dx|==|dy|!=0; orthogonal if exactly one of dx, dy is zero.
REQ-019 SHALL go SETUP -> DONE with move_valid=0 (done at T+2) on: zero move; non-line geometry; disallowed class per ALLOW_DIAG/ALLOW_ORTHO; any coordinate >= BOARD_N.
REQ-020 SHALL otherwise go to WALK with cursor = old + step, advancing one square per cycle.
REQ-021 SHALL, in WALK, go to DONE with move_valid=0 if cursor != new and board_in[cursor] is non-empty.
REQ-022 SHALL, in WALK, when cursor == new, evaluate the destination (REQ-028/029) and go to DONE.
REQ-023 SHALL achieve latency: d = max(|dx|,|dy|); unblocked done at T+2+d; block at intermediate k (1-based) gives done at T+2+k.
REQ-024 SHALL assert done for exactly the single DONE cycle, then return to IDLE; start is accepted again in the next cycle.
REQ-025 SHALL ignore start while busy; the latched request is not altered.
REQ-026 SHALL sample board_in combinationally each WALK cycle; the caller holds board_in stable while busy.

Reset
REQ-027 SHALL, on reset (including mid-WALK), enter IDLE next edge with busy=0, done=0, move_valid=0 and the cursor/latches cleared; reset overrides a simultaneous start.

Configuration
REQ-028 SHALL, with CHECK_SLIDER_CAPTURE_EN defined, accept the destination only if empty or its colour bit differs from the piece at old square; same colour -> move_valid=0.
REQ-029 SHALL, without CHECK_SLIDER_CAPTURE_EN, accept any destination contents (path check only); latency is identical in both builds.

Structure
REQ-030 SHALL place in shared package chess_pkg: EMPTY piece code (0), colour bit index (PIECE_W-1), and the slider state enum typedef.
REQ-031 SHALL factor geometry classification and step signs into one combinational sub-module slider_step_gen.

Verification
REQ-032 SHALL cover: queen build, empty board, (0,0)->(7,7) -> done at T+9, move_valid=1, busy high T+1..T+9.
REQ-033 SHALL cover: rook build (ALLOW_DIAG=0), (2,2)->(5,5) -> done at T+2, move_valid=0.
REQ-034 SHALL cover: queen, (3,0)->(3,7) with piece at (3,4) -> done at T+6, move_valid=0.
REQ-035 SHALL cover: capture build, white at (1,1), white at (4,4), move (1,1)->(4,4) -> move_valid=0; black at (4,4) -> move_valid=1.
REQ-036 SHALL cover: start pulsed at T+3 during an active walk -> ignored; reset asserted at T+3 -> IDLE at T+4, all outputs 0.
REQ-037 SHALL cover: BOARD_N=6, (0,0)->(6,6) -> done at T+2, move_valid=0.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess definitions: empty-square code, colour-bit location and slider FSM states.
package chess_pkg;

  localparam int unsigned EMPTY = 0;

  // The colour flag is the top bit of a piece code.
  function automatic int unsigned colour_bit(input int unsigned piece_w);
    return piece_w - 1;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WALK  = 2'd2,
    S_DONE  = 2'd3
  } slider_state_e;

endpackage

// File: rtl/slider_step_gen.sv
// Combinational move geometry: per-axis step (+1/-1/0 as a modular increment) and line class.
module slider_step_gen
  import chess_pkg::*;
#(
  parameter int unsigned COORD_W = 3
) (
  input  logic [COORD_W-1:0] old_x,
  input  logic [COORD_W-1:0] old_y,
  input  logic [COORD_W-1:0] new_x,
  input  logic [COORD_W-1:0] new_y,
  output logic [COORD_W-1:0] step_x_c,
  output logic [COORD_W-1:0] step_y_c,
  output logic               diag_c,
  output logic               ortho_c,
  output logic               zero_c
);

  localparam int unsigned DW = COORD_W + 1;

  logic signed [DW-1:0] dx;
  logic signed [DW-1:0] dy;
  logic        [DW-1:0] adx;
  logic        [DW-1:0] ady;

  // One extra bit keeps the signed difference of two unsigned coordinates exact.
  always_comb begin
    dx       = signed'({1'b0, new_x}) - signed'({1'b0, old_x});
    dy       = signed'({1'b0, new_y}) - signed'({1'b0, old_y});
    adx      = dx[DW-1] ? $unsigned(-dx) : $unsigned(dx);
    ady      = dy[DW-1] ? $unsigned(-dy) : $unsigned(dy);
    step_x_c = dx[DW-1] ? '1 : ((dx != '0) ? COORD_W'(1) : '0);
    step_y_c = dy[DW-1] ? '1 : ((dy != '0) ? COORD_W'(1) : '0);
    zero_c   = (dx == '0) && (dy == '0);
    diag_c   = (adx == ady) && (adx != '0);
    ortho_c  = (dx == '0) != (dy == '0);
  end

endmodule

// File: rtl/check_slider.sv
// Sliding-piece path checker: walks from source to destination one square per cycle.
// Define CHECK_SLIDER_CAPTURE_EN to also reject a destination holding a same-colour piece.
module check_slider
  import chess_pkg::*;
#(
  parameter int unsigned BOARD_N     = 8,
  parameter int unsigned COORD_W     = $clog2(BOARD_N),
  parameter int unsigned PIECE_W     = 4,
  parameter bit          ALLOW_DIAG  = 1'b1,
  parameter bit          ALLOW_ORTHO = 1'b1
) (
  input  logic                                       CLOCK_50,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [COORD_W-1:0]                         old_x,
  input  logic [COORD_W-1:0]                         old_y,
  input  logic [COORD_W-1:0]                         new_x,
  input  logic [COORD_W-1:0]                         new_y,
  input  logic [BOARD_N-1:0][BOARD_N-1:0][PIECE_W-1:0] board_in,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       move_valid
);

  localparam logic [COORD_W:0] LIM = (COORD_W + 1)'(BOARD_N);

  slider_state_e        state;
  logic [COORD_W-1:0]   ox, oy, nx, ny;
  logic [COORD_W-1:0]   cx, cy;

  logic [COORD_W-1:0]   step_x_c, step_y_c;
  logic                 diag_c, ortho_c, zero_c;
  logic                 in_range_c, geom_ok_c, at_dest_c, dest_ok_c;
  logic [PIECE_W-1:0]   cur_piece_c;

  slider_step_gen #(
    .COORD_W (COORD_W)
  ) u_step (
    .old_x    (ox),
    .old_y    (oy),
    .new_x    (nx),
    .new_y    (ny),
    .step_x_c (step_x_c),
    .step_y_c (step_y_c),
    .diag_c   (diag_c),
    .ortho_c  (ortho_c),
    .zero_c   (zero_c)
  );

  assign in_range_c  = ({1'b0, ox} < LIM) && ({1'b0, oy} < LIM) &&
                       ({1'b0, nx} < LIM) && ({1'b0, ny} < LIM);
  assign geom_ok_c   = !zero_c && ((diag_c && ALLOW_DIAG) || (ortho_c && ALLOW_ORTHO));
  assign at_dest_c   = (cx == nx) && (cy == ny);
  assign cur_piece_c = board_in[cx][cy];

`ifdef CHECK_SLIDER_CAPTURE_EN
  localparam int unsigned CB = colour_bit(PIECE_W);
  logic [PIECE_W-1:0] src_piece_c;
  assign src_piece_c = board_in[ox][oy];
  // Destination is legal if empty or occupied by the opposing colour.
  assign dest_ok_c   = (cur_piece_c == PIECE_W'(EMPTY)) || (cur_piece_c[CB] != src_piece_c[CB]);
`else
  assign dest_ok_c   = 1'b1;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      move_valid <= 1'b0;
      ox         <= '0;
      oy         <= '0;
      nx         <= '0;
      ny         <= '0;
      cx         <= '0;
      cy         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ox         <= old_x;
            oy         <= old_y;
            nx         <= new_x;
            ny         <= new_y;
            busy       <= 1'b1;
            move_valid <= 1'b0;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (!in_range_c || !geom_ok_c) begin
            done       <= 1'b1;
            move_valid <= 1'b0;
            state      <= S_DONE;
          end else begin
            cx    <= ox + step_x_c;
            cy    <= oy + step_y_c;
            state <= S_WALK;
          end
        end
        S_WALK: begin
          // Destination contents only matter once the cursor reaches it.
          if (at_dest_c) begin
            done       <= 1'b1;
            move_valid <= dest_ok_c;
            state      <= S_DONE;
          end else if (cur_piece_c != PIECE_W'(EMPTY)) begin
            done       <= 1'b1;
            move_valid <= 1'b0;
            state      <= S_DONE;
          end else begin
            cx <= cx + step_x_c;
            cy <= cy + step_y_c;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_check_slider.sv
// Bench for check_slider: queen, rook and 6x6 instances against a path model.
module tb_check_slider;
  import chess_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 3;
  localparam int unsigned PW = 4;
  localparam int unsigned N6 = 6;

  typedef logic [N-1:0][N-1:0][PW-1:0]   board8_t;
  typedef logic [N6-1:0][N6-1:0][PW-1:0] board6_t;

  typedef struct {
    int ox, oy, nx, ny, bx, by, blk, ql, qv, rl, rv;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, gl, q_start;
  logic [CW-1:0] old_x, old_y, new_x, new_y;
  board8_t       board;
  logic          q_busy, q_done, q_valid;
  logic          r_busy, r_done, r_valid;

  logic          s_start;
  logic [CW-1:0] s_ox, s_oy, s_nx, s_ny;
  board6_t       s_board;
  logic          s_busy, s_done, s_valid;

  int checks = 0;
  int errors = 0;
  vec_t vecs [9];

  assign q_start = start | gl;

  check_slider #(.BOARD_N(N)) u_queen (
    .CLOCK_50(clk), .reset(reset), .start(q_start),
    .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
    .board_in(board), .busy(q_busy), .done(q_done), .move_valid(q_valid));

  check_slider #(.BOARD_N(N), .ALLOW_DIAG(1'b0)) u_rook (
    .CLOCK_50(clk), .reset(reset), .start(start),
    .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
    .board_in(board), .busy(r_busy), .done(r_done), .move_valid(r_valid));

  check_slider #(.BOARD_N(N6)) u_n6 (
    .CLOCK_50(clk), .reset(reset), .start(s_start),
    .old_x(s_ox), .old_y(s_oy), .new_x(s_nx), .new_y(s_ny),
    .board_in(s_board), .busy(s_busy), .done(s_done), .move_valid(s_valid));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Expected latency (cycles after acceptance) and verdict from the move rules.
  function automatic void model(input int ox, oy, nx, ny, input board8_t b, input bit diag,
                                output int lat, output int ok);
    int dx, dy, ax, ay, sx, sy, d;
    logic [PW-1:0] dst, src;
    dx = nx - ox; dy = ny - oy;
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    sx = (dx > 0) ? 1 : ((dx < 0) ? -1 : 0);
    sy = (dy > 0) ? 1 : ((dy < 0) ? -1 : 0);
    lat = 2; ok = 0;
    if (!((ax == ay && ax != 0 && diag) || ((dx == 0) != (dy == 0)))) return;
    d = (ax > ay) ? ax : ay;
    for (int k = 1; k < d; k++) begin
      if (b[CW'(ox + k*sx)][CW'(oy + k*sy)] != '0) begin
        lat = 2 + k;
        return;
      end
    end
    lat = 2 + d; ok = 1;
    dst = b[CW'(nx)][CW'(ny)];
    src = b[CW'(ox)][CW'(oy)];
`ifdef CHECK_SLIDER_CAPTURE_EN
    if (dst != '0 && dst[PW-1] == src[PW-1]) ok = 0;
`else
    if (dst[0] === 1'bx || src[0] === 1'bx) ok = 0;
`endif
  endfunction

  // Starts a move on the queen and rook instances from the current negedge.
  task automatic run_move(input int ox, oy, nx, ny, input int eql, eqv, erl, erv,
                          input int glitch, input string tag);
    int qs, rs, qd, rd, qb, rb, qv, rv, last;
    qs = -1; rs = -1; qd = 0; rd = 0; qb = 0; rb = 0; qv = 0; rv = 0;
    last = ((eql > erl) ? eql : erl) + 1;
    old_x = CW'(ox); old_y = CW'(oy); new_x = CW'(nx); new_y = CW'(ny);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      gl = (c == glitch);
      if (c == glitch) begin
        old_x = CW'($urandom); old_y = CW'($urandom);
        new_x = CW'($urandom); new_y = CW'($urandom);
      end
      if (q_busy) qb++;
      if (r_busy) rb++;
      if (q_done) begin qd++; if (qs < 0) begin qs = c; qv = int'(q_valid); end end
      if (r_done) begin rd++; if (rs < 0) begin rs = c; rv = int'(r_valid); end end
      if (c == last) begin
        check({tag, " q_valid_held"}, int'(q_valid), eqv);
        check({tag, " r_valid_held"}, int'(r_valid), erv);
      end else begin
        @(negedge clk);
      end
    end
    gl = 1'b0;
    check({tag, " q_done_cycle"}, qs, eql);
    check({tag, " q_done_count"}, qd, 1);
    check({tag, " q_valid"}, qv, eqv);
    check({tag, " q_busy_cycles"}, qb, eql);
    check({tag, " r_done_cycle"}, rs, erl);
    check({tag, " r_done_count"}, rd, 1);
    check({tag, " r_valid"}, rv, erv);
    check({tag, " r_busy_cycles"}, rb, erl);
  endtask

  task automatic run6(input int ox, oy, nx, ny, input int el, ev, input string tag);
    int s, v;
    s = -1; v = 0;
    s_ox = CW'(ox); s_oy = CW'(oy); s_nx = CW'(nx); s_ny = CW'(ny);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int c = 1; c <= el + 1; c++) begin
      if (s_done && s < 0) begin s = c; v = int'(s_valid); end
      @(negedge clk);
    end
    check({tag, " done_cycle"}, s, el);
    check({tag, " valid"}, v, ev);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; gl = 1'b0; s_start = 1'b0;
    old_x = '0; old_y = '0; new_x = '0; new_y = '0; board = '0;
    s_ox = '0; s_oy = '0; s_nx = '0; s_ny = '0; s_board = '0;

    vecs[0] = '{0, 0, 7, 7, 0, 0, 0, 9, 1, 2, 0};
    vecs[1] = '{2, 2, 5, 5, 0, 0, 0, 5, 1, 2, 0};
    vecs[2] = '{3, 0, 3, 7, 3, 4, 1, 6, 0, 6, 0};
    vecs[3] = '{4, 4, 4, 4, 0, 0, 0, 2, 0, 2, 0};
    vecs[4] = '{0, 0, 1, 2, 0, 0, 0, 2, 0, 2, 0};
    vecs[5] = '{7, 0, 0, 0, 0, 0, 0, 9, 1, 9, 1};
    vecs[6] = '{5, 6, 5, 5, 0, 0, 0, 3, 1, 3, 1};
    vecs[7] = '{6, 1, 1, 6, 5, 2, 1, 3, 0, 2, 0};
    vecs[8] = '{7, 7, 0, 0, 1, 1, 1, 8, 0, 2, 0};

    repeat (3) @(negedge clk);
    check("rst q_busy", int'(q_busy), 0);
    check("rst q_done", int'(q_done), 0);
    check("rst q_valid", int'(q_valid), 0);
    check("rst r_busy", int'(r_busy), 0);
    check("rst s_busy", int'(s_busy), 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      board = '0;
      if (vecs[i].blk != 0) board[CW'(vecs[i].bx)][CW'(vecs[i].by)] = 4'h3;
      run_move(vecs[i].ox, vecs[i].oy, vecs[i].nx, vecs[i].ny, vecs[i].ql, vecs[i].qv,
               vecs[i].rl, vecs[i].rv, 0, $sformatf("vec%0d", i));
    end

    // Start pulsed during an active walk must not disturb the latched request.
    board = '0;
    run_move(0, 0, 7, 7, 9, 1, 2, 0, 3, "glitch");

    // Reset in the middle of a walk, then reset racing a start.
    old_x = 3'd0; old_y = 3'd0; new_x = 3'd7; new_y = 3'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst q_busy", int'(q_busy), 0);
    check("midrst q_done", int'(q_done), 0);
    check("midrst q_valid", int'(q_valid), 0);
    check("midrst r_busy", int'(r_busy), 0);
    start = 1'b1;
    @(negedge clk);
    check("rst_vs_start q_busy", int'(q_busy), 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst idle q_busy", int'(q_busy), 0);
    run_move(7, 0, 0, 0, 9, 1, 9, 1, 0, "post_rst");

    // Colour handling at the destination square.
    board = '0;
    board[1][1] = 4'h1;
    board[4][4] = 4'h2;
`ifdef CHECK_SLIDER_CAPTURE_EN
    run_move(1, 1, 4, 4, 5, 0, 2, 0, 0, "same_colour");
`else
    run_move(1, 1, 4, 4, 5, 1, 2, 0, 0, "same_colour");
`endif
    board[4][4] = 4'h9;
    run_move(1, 1, 4, 4, 5, 1, 2, 0, 0, "opp_colour");

    // 6x6 board: coordinates past the edge are rejected immediately.
    run6(0, 0, 6, 6, 2, 0, "n6 off_board");
    run6(0, 0, 5, 5, 7, 1, "n6 corner");

    for (int it = 0; it < 150; it++) begin
      int ox, oy, nx, ny, sx, sy, maxl, len, ql, qv, rl, rv;
      for (int x = 0; x < N; x++)
        for (int y = 0; y < N; y++)
          board[x][y] = ($urandom_range(0, 5) == 0) ? PW'($urandom_range(1, 15)) : '0;
      ox = int'($urandom_range(0, 7));
      oy = int'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        nx = int'($urandom_range(0, 7));
        ny = int'($urandom_range(0, 7));
      end else begin
        do begin
          sx = int'($urandom_range(0, 2)) - 1;
          sy = int'($urandom_range(0, 2)) - 1;
        end while (sx == 0 && sy == 0);
        maxl = 0;
        while (ox + (maxl+1)*sx >= 0 && ox + (maxl+1)*sx < N &&
               oy + (maxl+1)*sy >= 0 && oy + (maxl+1)*sy < N) maxl++;
        len = (maxl == 0) ? 0 : int'($urandom_range(1, maxl));
        nx = ox + len*sx;
        ny = oy + len*sy;
      end
      model(ox, oy, nx, ny, board, 1'b1, ql, qv);
      model(ox, oy, nx, ny, board, 1'b0, rl, rv);
      run_move(ox, oy, nx, ny, ql, qv, rl, rv, 0, $sformatf("rnd%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
